// File: rtl/core_pkg.sv
// Shared definitions for the pipelined MIPS core: ALU select codes, default widths
// and the EX/MEM pipeline entry.
package core_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   localparam logic [3:0] ALU_AND   = 4'd0;
   localparam logic [3:0] ALU_OR    = 4'd1;
   localparam logic [3:0] ALU_XOR   = 4'd2;
   localparam logic [3:0] ALU_NOR   = 4'd3;
   localparam logic [3:0] ALU_ADD   = 4'd4;
   localparam logic [3:0] ALU_SUB   = 4'd5;
   localparam logic [3:0] ALU_SLT   = 4'd6;
   localparam logic [3:0] ALU_SLTU  = 4'd7;
   localparam logic [3:0] ALU_SHIFT = 4'd8;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic              zero;
      logic [DATA_W-1:0] store_data;
      logic [REG_AW-1:0] rd;
      logic              reg_wr;
      logic              mem_rd;
      logic              mem_wr;
   } ex_mem_t;

   localparam ex_mem_t EX_MEM_RESET = '{
      result:     '0,
      zero:       1'b1,
      store_data: '0,
      rd:         '0,
      reg_wr:     1'b0,
      mem_rd:     1'b0,
      mem_wr:     1'b0
   };

endpackage

// File: rtl/alu_result_mux.sv
// Combinational result select for the execute stage. Builds one EX/MEM entry,
// including the zero flag; unknown select codes become harmless bubbles.
module alu_result_mux
   import core_pkg::*;
(
   input  logic [3:0]        alu_sel,
   input  logic [DATA_W-1:0] and_in,
   input  logic [DATA_W-1:0] or_in,
   input  logic [DATA_W-1:0] xor_in,
   input  logic [DATA_W-1:0] nor_in,
   input  logic [DATA_W-1:0] sum_in,
   input  logic [DATA_W-1:0] diff_in,
   input  logic              sub_ovf,
   input  logic              sub_borrow,
   input  logic [DATA_W-1:0] shift_in,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic [REG_AW-1:0] rd_in,
   input  logic              reg_wr_in,
   input  logic              mem_rd_in,
   input  logic              mem_wr_in,
   output ex_mem_t           entry
);

   logic [DATA_W-1:0] res;
   logic              legal;

   always_comb begin
      res   = '0;
      legal = 1'b1;
      unique case (alu_sel)
         ALU_AND:   res = and_in;
         ALU_OR:    res = or_in;
         ALU_XOR:   res = xor_in;
         ALU_NOR:   res = nor_in;
         ALU_ADD:   res = sum_in;
         ALU_SUB:   res = diff_in;
         // signed less-than: sign of a-b corrected by overflow
         ALU_SLT:   res = {{(DATA_W-1){1'b0}}, diff_in[DATA_W-1] ^ sub_ovf};
         ALU_SLTU:  res = {{(DATA_W-1){1'b0}}, sub_borrow};
         ALU_SHIFT: res = shift_in;
         default: begin
            res   = '0;
            legal = 1'b0;
         end
      endcase
   end

   always_comb begin
      entry            = EX_MEM_RESET;
      entry.result     = res;
      entry.zero       = (res == '0);
      entry.store_data = store_data_in;
      entry.rd         = rd_in;
      entry.reg_wr     = reg_wr_in & legal;
      entry.mem_rd     = mem_rd_in & legal;
      entry.mem_wr     = mem_wr_in & legal;
   end

endmodule

// File: rtl/ex_result_stage.sv
// Execute-stage result select plus EX/MEM register with a two-entry skid buffer,
// so in_ready is a flop and never depends combinationally on out_ready.
module ex_result_stage
   import core_pkg::*;
#(
   parameter int DATA_W = core_pkg::DATA_W,
   parameter int REG_AW = core_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        alu_sel,
   input  logic [DATA_W-1:0] and_in,
   input  logic [DATA_W-1:0] or_in,
   input  logic [DATA_W-1:0] xor_in,
   input  logic [DATA_W-1:0] nor_in,
   input  logic [DATA_W-1:0] sum_in,
   input  logic [DATA_W-1:0] diff_in,
   input  logic              sub_ovf,
   input  logic              sub_borrow,
   input  logic [DATA_W-1:0] shift_in,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic [REG_AW-1:0] rd_in,
   input  logic              reg_wr_in,
   input  logic              mem_rd_in,
   input  logic              mem_wr_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic [DATA_W-1:0] store_data,
   output logic [REG_AW-1:0] rd,
   output logic              reg_wr,
   output logic              mem_rd,
   output logic              mem_wr
);

   ex_mem_t cur_entry;
   ex_mem_t main_q, main_d;
   ex_mem_t skid_q, skid_d;
   logic    out_valid_q, out_valid_d;
   logic    skid_valid_q, skid_valid_d;
   logic    in_ready_q;
   logic    accept;
   logic    main_load;

   alu_result_mux u_mux (
      .alu_sel       (alu_sel),
      .and_in        (and_in),
      .or_in         (or_in),
      .xor_in        (xor_in),
      .nor_in        (nor_in),
      .sum_in        (sum_in),
      .diff_in       (diff_in),
      .sub_ovf       (sub_ovf),
      .sub_borrow    (sub_borrow),
      .shift_in      (shift_in),
      .store_data_in (store_data_in),
      .rd_in         (rd_in),
      .reg_wr_in     (reg_wr_in),
      .mem_rd_in     (mem_rd_in),
      .mem_wr_in     (mem_wr_in),
      .entry         (cur_entry)
   );

   assign accept    = in_valid && in_ready_q && !flush;
   assign main_load = !out_valid_q || out_ready;

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         // squash occupancy only; data fields keep their old contents
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_load) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = accept;
            if (accept) skid_d = cur_entry;
         end else begin
            out_valid_d = accept;
            if (accept) main_d = cur_entry;
         end
      end else if (accept) begin
         skid_d       = cur_entry;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q       <= EX_MEM_RESET;
         skid_q       <= EX_MEM_RESET;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= !skid_valid_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign result     = main_q.result;
   assign zero       = main_q.zero;
   assign store_data = main_q.store_data;
   assign rd         = main_q.rd;
   // control strobes must never fire for an empty slot
   assign reg_wr     = main_q.reg_wr & out_valid_q;
   assign mem_rd     = main_q.mem_rd & out_valid_q;
   assign mem_wr     = main_q.mem_wr & out_valid_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage: select table, SLT/SLTU corners,
// back-pressure ordering, flush, illegal ops and asynchronous reset.
module tb_ex_result_stage;
   import core_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        alu_sel;
   logic [31:0]       and_in, or_in, xor_in, nor_in, sum_in, diff_in, shift_in, store_data_in;
   logic              sub_ovf, sub_borrow;
   logic [4:0]        rd_in;
   logic              reg_wr_in, mem_rd_in, mem_wr_in;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       result;
   logic              zero;
   logic [31:0]       store_data;
   logic [4:0]        rd;
   logic              reg_wr, mem_rd, mem_wr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ex_result_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .alu_sel(alu_sel),
      .and_in(and_in), .or_in(or_in), .xor_in(xor_in), .nor_in(nor_in),
      .sum_in(sum_in), .diff_in(diff_in), .sub_ovf(sub_ovf), .sub_borrow(sub_borrow),
      .shift_in(shift_in), .store_data_in(store_data_in), .rd_in(rd_in),
      .reg_wr_in(reg_wr_in), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
      .store_data(store_data), .rd(rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present_sum(input logic [31:0] v);
      in_valid = 1'b1;
      alu_sel  = ALU_ADD;
      sum_in   = v;
   endtask

   logic [3:0]  sel_tab [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8};
   logic [31:0] exp_tab [7] = '{32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C3, 32'h0000_00D4,
                                32'h0000_00E5, 32'h0000_0F06, 32'h0000_0808};

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alu_sel = 4'd0; and_in = '0; or_in = '0; xor_in = '0; nor_in = '0;
      sum_in = '0; diff_in = '0; shift_in = '0; store_data_in = '0;
      sub_ovf = 1'b0; sub_borrow = 1'b0; rd_in = '0;
      reg_wr_in = 1'b0; mem_rd_in = 1'b0; mem_wr_in = 1'b0;
      step(); step();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_zero", 32'(zero), 32'd1);
      check("rst_result", result, 32'd0);
      check("rst_ctrl", {29'd0, reg_wr, mem_rd, mem_wr}, 32'd0);
      rst_n = 1'b1;

      // first transaction: AND
      in_valid = 1'b1; alu_sel = ALU_AND; and_in = 32'h0000_00F0; out_ready = 1'b1;
      rd_in = 5'd3; reg_wr_in = 1'b1; store_data_in = 32'h1234_5678;
      step();
      check("and_result", result, 32'h0000_00F0);
      check("and_zero", 32'(zero), 32'd0);
      check("and_valid", 32'(out_valid), 32'd1);
      check("and_rd", 32'(rd), 32'd3);
      check("and_reg_wr", 32'(reg_wr), 32'd1);
      check("and_store_data", store_data, 32'h1234_5678);

      // SLT / SLTU corners
      alu_sel = ALU_SLT; diff_in = 32'h8000_0001; sub_ovf = 1'b1;
      step();
      check("slt_ovf", result, 32'd0);
      check("slt_ovf_zero", 32'(zero), 32'd1);
      sub_ovf = 1'b0;
      step();
      check("slt_noovf", result, 32'd1);
      alu_sel = ALU_SLTU; sub_borrow = 1'b1;
      step();
      check("sltu_borrow", result, 32'd1);

      // select table
      and_in = 32'hA1; or_in = 32'hB2; xor_in = 32'hC3; nor_in = 32'hD4;
      sum_in = 32'hE5; diff_in = 32'hF06; shift_in = 32'h808; mem_rd_in = 1'b1;
      for (int i = 0; i < 7; i++) begin
         alu_sel = sel_tab[i];
         step();
         check($sformatf("sel%0d", sel_tab[i]), result, exp_tab[i]);
      end
      check("sel_mem_rd", 32'(mem_rd), 32'd1);
      mem_rd_in = 1'b0;

      // drain, then back-pressure A,B,C
      in_valid = 1'b0;
      step();
      check("drain_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      present_sum(32'hA);
      step();
      check("bp_A_out", result, 32'hA);
      check("bp_A_ready", 32'(in_ready), 32'd1);
      present_sum(32'hB);
      step();
      check("bp_hold_A", result, 32'hA);
      check("bp_skid_full", 32'(in_ready), 32'd0);
      present_sum(32'hC);
      step();
      check("bp_still_A", result, 32'hA);
      check("bp_C_blocked", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      step();
      check("bp_B_out", result, 32'hB);
      check("bp_B_valid", 32'(out_valid), 32'd1);
      check("bp_ready_back", 32'(in_ready), 32'd1);
      step();
      check("bp_C_out", result, 32'hC);
      check("bp_C_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      step();
      check("bp_empty", 32'(out_valid), 32'd0);

      // flush while full
      out_ready = 1'b0;
      present_sum(32'hA);
      step();
      present_sum(32'hB);
      step();
      check("fl_full", 32'(in_ready), 32'd0);
      present_sum(32'hD); flush = 1'b1;
      step();
      check("fl_valid", 32'(out_valid), 32'd0);
      check("fl_ready", 32'(in_ready), 32'd1);
      check("fl_reg_wr", 32'(reg_wr), 32'd0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      check("fl_no_D", 32'(out_valid), 32'd0);

      // illegal select becomes a valid bubble
      in_valid = 1'b1; alu_sel = 4'd12; reg_wr_in = 1'b1; mem_wr_in = 1'b1;
      step();
      check("ill_valid", 32'(out_valid), 32'd1);
      check("ill_result", result, 32'd0);
      check("ill_zero", 32'(zero), 32'd1);
      check("ill_ctrl", {30'd0, reg_wr, mem_wr}, 32'd0);
      mem_wr_in = 1'b0;

      // async reset in the middle of a stall
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      present_sum(32'h55);
      step();
      present_sum(32'h66);
      step();
      check("ar_stalled", {30'd0, out_valid, in_ready}, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(out_valid), 32'd0);
      check("ar_ready", 32'(in_ready), 32'd1);
      check("ar_zero", 32'(zero), 32'd1);
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check("ar_after", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
